// File: rtl/ptw_arbiter_pkg.sv
// Shared types and constants for the two-TLB page-table-walker arbiter.
package ptw_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } ptw_state_e;

  localparam int unsigned REQ_ITLB   = 0;
  localparam int unsigned REQ_DTLB   = 1;
  localparam int unsigned PAGE_SHIFT = 12;

endpackage

// File: rtl/ptw_arbiter_rr_arb2.sv
// Two-input round-robin grant: sole requester wins, ties go to the pointer.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Arbitrates ITLB and DTLB misses onto one shared PTW, one walk at a time,
// merging same-page misses into a single walk.
module ptw_arbiter
  import ptw_arbiter_pkg::*;
#(
  parameter int unsigned VA_W  = 32,
  parameter int unsigned PTE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             itlb_req_valid_i,
  output logic             itlb_req_ready_o,
  input  logic [VA_W-1:0]  itlb_vaddr_i,
  output logic             itlb_resp_valid_o,
  input  logic             itlb_resp_ready_i,
  output logic [PTE_W-1:0] itlb_pte_o,
  input  logic             dtlb_req_valid_i,
  output logic             dtlb_req_ready_o,
  input  logic [VA_W-1:0]  dtlb_vaddr_i,
  output logic             dtlb_resp_valid_o,
  input  logic             dtlb_resp_ready_i,
  output logic [PTE_W-1:0] dtlb_pte_o,
  output logic             ptw_req_valid_o,
  input  logic             ptw_req_ready_i,
  output logic [VA_W-1:0]  ptw_vaddr_o,
  input  logic             ptw_resp_valid_i,
  output logic             ptw_resp_ready_o,
  input  logic [PTE_W-1:0] ptw_pte_i,
  output logic             busy_o
);

  ptw_state_e       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [VA_W-1:0]  vaddr_q, vaddr_d;
  logic [PTE_W-1:0] pte_q, pte_d;

  logic [1:0] req_vld;
  logic [1:0] arb_gnt;
  logic [1:0] req_rdy;
  logic [1:0] req_hs;
  logic [1:0] resp_hs;
  logic       coalesce;

  assign req_vld[REQ_ITLB] = itlb_req_valid_i;
  assign req_vld[REQ_DTLB] = dtlb_req_valid_i;

  rr_arb2 u_rr_arb2 (
    .req_i (req_vld),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  // Misses to the same page share one walk.
  assign coalesce = (&req_vld) &&
                    (itlb_vaddr_i[VA_W-1:PAGE_SHIFT] == dtlb_vaddr_i[VA_W-1:PAGE_SHIFT]);

  assign req_hs             = req_rdy & req_vld;
  assign resp_hs[REQ_ITLB]  = itlb_resp_valid_o & itlb_resp_ready_i;
  assign resp_hs[REQ_DTLB]  = dtlb_resp_valid_o & dtlb_resp_ready_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      owner_q  <= '0;
      vaddr_q  <= '0;
      pte_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      vaddr_q  <= vaddr_d;
      pte_q    <= pte_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    vaddr_d  = vaddr_q;
    pte_d    = pte_q;
    unique case (state_q)
      StIdle: begin
        if (|req_hs) begin
          state_d  = StIssue;
          owner_d  = req_hs;
          vaddr_d  = arb_gnt[REQ_DTLB] ? dtlb_vaddr_i : itlb_vaddr_i;
          // Pointer moves to whoever did not win the arbitration.
          rr_ptr_d = ~arb_gnt[REQ_DTLB];
        end
      end
      StIssue: begin
        if (ptw_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (ptw_resp_valid_i) begin
          pte_d   = ptw_pte_i;
          state_d = StResp;
        end
      end
      StResp: begin
        owner_d = owner_q & ~resp_hs;
        if (owner_d == 2'b00) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_rdy           = 2'b00;
    ptw_req_valid_o   = 1'b0;
    ptw_resp_ready_o  = 1'b0;
    itlb_resp_valid_o = 1'b0;
    dtlb_resp_valid_o = 1'b0;
    busy_o            = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy_o  = 1'b0;
        req_rdy = coalesce ? 2'b11 : arb_gnt;
      end
      StIssue: ptw_req_valid_o = 1'b1;
      StWait:  ptw_resp_ready_o = 1'b1;
      StResp: begin
        itlb_resp_valid_o = owner_q[REQ_ITLB];
        dtlb_resp_valid_o = owner_q[REQ_DTLB];
      end
      default: busy_o = 1'b1;
    endcase
  end

  assign itlb_req_ready_o = req_rdy[REQ_ITLB];
  assign dtlb_req_ready_o = req_rdy[REQ_DTLB];
  assign ptw_vaddr_o      = vaddr_q;
  assign itlb_pte_o       = pte_q;
  assign dtlb_pte_o       = pte_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: a walk-level model checked every cycle, plus
// literal expectations on event order and values.
module tb_ptw_arbiter;

  localparam int VA_W  = 32;
  localparam int PTE_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             itlb_req_valid_i, itlb_req_ready_o, itlb_resp_valid_o, itlb_resp_ready_i;
  logic [VA_W-1:0]  itlb_vaddr_i;
  logic [PTE_W-1:0] itlb_pte_o;
  logic             dtlb_req_valid_i, dtlb_req_ready_o, dtlb_resp_valid_o, dtlb_resp_ready_i;
  logic [VA_W-1:0]  dtlb_vaddr_i;
  logic [PTE_W-1:0] dtlb_pte_o;
  logic             ptw_req_valid_o, ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ready_o;
  logic [VA_W-1:0]  ptw_vaddr_o;
  logic [PTE_W-1:0] ptw_pte_i;
  logic             busy_o;

  always #5 clk = ~clk;

  ptw_arbiter #(.VA_W(VA_W), .PTE_W(PTE_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .itlb_req_valid_i  (itlb_req_valid_i),
    .itlb_req_ready_o  (itlb_req_ready_o),
    .itlb_vaddr_i      (itlb_vaddr_i),
    .itlb_resp_valid_o (itlb_resp_valid_o),
    .itlb_resp_ready_i (itlb_resp_ready_i),
    .itlb_pte_o        (itlb_pte_o),
    .dtlb_req_valid_i  (dtlb_req_valid_i),
    .dtlb_req_ready_o  (dtlb_req_ready_o),
    .dtlb_vaddr_i      (dtlb_vaddr_i),
    .dtlb_resp_valid_o (dtlb_resp_valid_o),
    .dtlb_resp_ready_i (dtlb_resp_ready_i),
    .dtlb_pte_o        (dtlb_pte_o),
    .ptw_req_valid_o   (ptw_req_valid_o),
    .ptw_req_ready_i   (ptw_req_ready_i),
    .ptw_vaddr_o       (ptw_vaddr_o),
    .ptw_resp_valid_i  (ptw_resp_valid_i),
    .ptw_resp_ready_o  (ptw_resp_ready_o),
    .ptw_pte_i         (ptw_pte_i),
    .busy_o            (busy_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting, got nothing expected event", name);
  endtask

  // ---------------- walk-level model ----------------
  logic             m_issue, m_wait, m_rr;
  logic [1:0]       m_owners, m_owed;
  logic [VA_W-1:0]  m_vaddr;
  logic [PTE_W-1:0] m_pte;
  logic             m_idle;
  logic [1:0]       m_rdy, m_acc;

  function automatic logic [1:0] exp_ready(input logic idle, input logic iv, input logic dv,
                                           input logic [31:0] ia, input logic [31:0] da,
                                           input logic rr);
    if (!idle) return 2'b00;
    if (iv && dv) begin
      if (ia[31:12] == da[31:12]) return 2'b11;
      return rr ? 2'b10 : 2'b01;
    end
    return {dv, iv};
  endfunction

  assign m_idle = !m_issue && !m_wait && (m_owed == 2'b00);
  assign m_rdy  = exp_ready(m_idle, itlb_req_valid_i, dtlb_req_valid_i,
                            itlb_vaddr_i, dtlb_vaddr_i, m_rr);
  assign m_acc  = m_rdy & {dtlb_req_valid_i, itlb_req_valid_i};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_issue  <= 1'b0;
      m_wait   <= 1'b0;
      m_rr     <= 1'b0;
      m_owners <= 2'b00;
      m_owed   <= 2'b00;
      m_vaddr  <= '0;
      m_pte    <= '0;
    end else if (m_idle) begin
      if (m_acc != 2'b00) begin
        m_issue  <= 1'b1;
        m_owners <= m_acc;
        if (m_acc == 2'b11) m_vaddr <= m_rr ? dtlb_vaddr_i : itlb_vaddr_i;
        else                m_vaddr <= m_acc[0] ? itlb_vaddr_i : dtlb_vaddr_i;
        m_rr     <= (m_acc == 2'b11) ? ~m_rr : m_acc[0];
      end
    end else if (m_issue) begin
      if (ptw_req_ready_i) begin
        m_issue <= 1'b0;
        m_wait  <= 1'b1;
      end
    end else if (m_wait) begin
      if (ptw_resp_valid_i) begin
        m_wait <= 1'b0;
        m_pte  <= ptw_pte_i;
        m_owed <= m_owners;
      end
    end else begin
      m_owed <= m_owed & ~{dtlb_resp_ready_i, itlb_resp_ready_i};
    end
  end

  always @(negedge clk) begin
    check("itlb_req_ready", itlb_req_ready_o, m_rdy[0]);
    check("dtlb_req_ready", dtlb_req_ready_o, m_rdy[1]);
    check("ptw_req_valid", ptw_req_valid_o, m_issue);
    check("ptw_vaddr", ptw_vaddr_o, m_vaddr);
    check("ptw_resp_ready", ptw_resp_ready_o, m_wait);
    check("itlb_resp_valid", itlb_resp_valid_o, m_owed[0]);
    check("dtlb_resp_valid", dtlb_resp_valid_o, m_owed[1]);
    check("itlb_pte", itlb_pte_o, m_pte);
    check("dtlb_pte", dtlb_pte_o, m_pte);
    check("busy", busy_o, m_issue | m_wait | (m_owed != 2'b00));
  end

  // ---------------- event logs ----------------
  // 10+who = request grant, 20+who = response delivered
  int               ev_log[$];
  logic [PTE_W-1:0] pte_log[$];
  int               ptw_hs_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (itlb_req_valid_i && itlb_req_ready_o) ev_log.push_back(10);
      if (dtlb_req_valid_i && dtlb_req_ready_o) ev_log.push_back(11);
      if (itlb_resp_valid_o && itlb_resp_ready_i) begin
        ev_log.push_back(20);
        pte_log.push_back(itlb_pte_o);
      end
      if (dtlb_resp_valid_o && dtlb_resp_ready_i) begin
        ev_log.push_back(21);
        pte_log.push_back(dtlb_pte_o);
      end
      if (ptw_req_valid_o && ptw_req_ready_i) ptw_hs_cnt++;
    end
  end

  task automatic check_seq(input string name, input int e[$]);
    check({name, "_len"}, ev_log.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < ev_log.size()) check(name, ev_log[i], e[i]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ev_log.delete();
    pte_log.delete();
    ptw_hs_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    itlb_req_valid_i = 0; dtlb_req_valid_i = 0;
    itlb_resp_ready_i = 0; dtlb_resp_ready_i = 0;
    ptw_req_ready_i = 0; ptw_resp_valid_i = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  // Wait for any request handshake, then drop the valids selected by drop.
  task automatic accept(input logic [1:0] drop);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((itlb_req_valid_i && itlb_req_ready_o) || (dtlb_req_valid_i && dtlb_req_ready_o)) begin
        @(posedge clk);
        #1;
        if (drop[0]) itlb_req_valid_i = 0;
        if (drop[1]) dtlb_req_valid_i = 0;
        return;
      end
    end
    timeout("accept");
  endtask

  task automatic ptw_issue(input int stall);
    for (int i = 0; i < 40; i++) begin
      if (ptw_req_valid_o) begin
        repeat (stall) tick();
        ptw_req_ready_i = 1;
        tick();
        ptw_req_ready_i = 0;
        return;
      end
      tick();
    end
    timeout("ptw_issue");
  endtask

  task automatic ptw_respond(input logic [PTE_W-1:0] pte);
    ptw_resp_valid_i = 1;
    ptw_pte_i = pte;
    tick();
    ptw_resp_valid_i = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) return;
      tick();
    end
    timeout("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    itlb_req_valid_i = 0; dtlb_req_valid_i = 0;
    itlb_vaddr_i = '0; dtlb_vaddr_i = '0;
    itlb_resp_ready_i = 0; dtlb_resp_ready_i = 0;
    ptw_req_ready_i = 0; ptw_resp_valid_i = 0; ptw_pte_i = '0;
    ptw_hs_cnt = 0;

    // Single ITLB walk
    do_reset();
    check("rst_busy", busy_o, 0);
    check("rst_ptw_vaddr", ptw_vaddr_o, 0);
    itlb_resp_ready_i = 1;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_1000;
    accept(2'b01);
    check("t1_ptw_valid", ptw_req_valid_o, 1);
    check("t1_ptw_vaddr", ptw_vaddr_o, 32'h0000_1000);
    ptw_issue(0);
    ptw_respond(32'h1100_000F);
    check("t1_itlb_valid", itlb_resp_valid_o, 1);
    check("t1_itlb_pte", itlb_pte_o, 32'h1100_000F);
    check("t1_dtlb_valid", dtlb_resp_valid_o, 0);
    drain();

    // Simultaneous different pages: ITLB first, DTLB only after ITLB completes
    do_reset();
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 1;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_0000;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0040_0000;
    accept(2'b01);
    ptw_issue(0);
    ptw_respond(32'hAAAA_5555);
    accept(2'b10);
    check("t2_ptw_vaddr", ptw_vaddr_o, 32'h0040_0000);
    ptw_issue(0);
    ptw_respond(32'h0000_0000);
    drain();
    check_seq("t2_order", '{10, 20, 11, 21});
    if (pte_log.size() == 2) check("t2_dtlb_pte", pte_log[1], 32'h0000_0000);
    else timeout("t2_pte_log");

    // Three back-to-back ties alternate
    do_reset();
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 1;
    for (int r = 0; r < 3; r++) begin
      itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_5000;
      dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0000_9000;
      accept(2'b11);
      ptw_issue(0);
      ptw_respond(32'h100 + r);
      drain();
    end
    check_seq("t3_order", '{10, 20, 11, 21, 10, 20});

    // Coalesced same-page walk, DTLB slow to take its response
    do_reset();
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 0;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_2000;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0000_2ABC;
    accept(2'b11);
    ptw_issue(0);
    ptw_respond(32'h1200_0003);
    tick(); tick(); tick();
    check("t4_busy_held", busy_o, 1);
    check("t4_dtlb_valid_held", dtlb_resp_valid_o, 1);
    dtlb_resp_ready_i = 1;
    tick();
    check("t4_busy_done", busy_o, 0);
    check("t4_ptw_hs", ptw_hs_cnt, 1);
    check_seq("t4_order", '{10, 11, 20, 21});
    if (pte_log.size() == 2) begin
      check("t4_itlb_pte", pte_log[0], 32'h1200_0003);
      check("t4_dtlb_pte", pte_log[1], 32'h1200_0003);
    end else timeout("t4_pte_log");

    // PTW stalls, then requester stalls; second requester waits throughout
    do_reset();
    itlb_resp_ready_i = 0; dtlb_resp_ready_i = 1;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_7000;
    accept(2'b01);
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0000_8000;
    ptw_issue(5);
    ptw_respond(32'h7777_0001);
    repeat (4) tick();
    check("t5_itlb_valid", itlb_resp_valid_o, 1);
    check("t5_itlb_pte", itlb_pte_o, 32'h7777_0001);
    check("t5_dtlb_ready", dtlb_req_ready_o, 0);
    itlb_resp_ready_i = 1;
    accept(2'b10);
    ptw_issue(0);
    ptw_respond(32'h8888_0002);
    drain();
    check_seq("t5_order", '{10, 20, 11, 21});

    // Asynchronous reset while waiting on the PTW
    do_reset();
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 1;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_3000;
    accept(2'b01);
    ptw_issue(0);
    check("t6_in_wait", ptw_resp_ready_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_resp_ready", ptw_resp_ready_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_vaddr", ptw_vaddr_o, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h0000_3000;
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h0000_6000;
    accept(2'b11);
    ptw_issue(0);
    ptw_respond(32'hCAFE_0001);
    drain();
    check_seq("t6_order", '{10, 10, 20});
    if (pte_log.size() == 1) check("t6_pte", pte_log[0], 32'hCAFE_0001);
    else timeout("t6_pte_log");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ptw_arbiter.md
PTW_ARBITER -- requirements
Module: ptw_arbiter

Interface
REQ-001 SHALL have parameter VA_W, default 32, virtual address width.
REQ-002 SHALL have parameter PTE_W, default 32, page table entry width.
REQ-003 SHALL run on one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port itlb_req_valid_i  in  1  ITLB miss request valid.
REQ-006 SHALL have port itlb_req_ready_o  out  1  ITLB request accepted.
REQ-007 SHALL have port itlb_vaddr_i  in  VA_W  ITLB miss virtual address.
REQ-008 SHALL have port itlb_resp_valid_o  out  1  PTE for ITLB valid.
REQ-009 SHALL have port itlb_resp_ready_i  in  1  ITLB takes PTE.
REQ-010 SHALL have port itlb_pte_o  out  PTE_W  PTE returned to ITLB.
REQ-011 SHALL have dtlb_* ports identical to REQ-005..REQ-010, serving the DTLB.
REQ-012 SHALL have ports ptw_req_valid_o out 1, ptw_req_ready_i in 1, ptw_vaddr_o out VA_W: request channel to the shared PTW.
REQ-013 SHALL have ports ptw_resp_valid_i in 1, ptw_resp_ready_o out 1, ptw_pte_i in PTE_W: response channel from the PTW.
REQ-014 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with exactly one walk outstanding at a time.
REQ-016 In IDLE, ready SHALL be asserted combinationally to the winner only. Winner = sole valid requester; on a tie, the requester indicated by rr_ptr (0 = ITLB).
REQ-017 On an IDLE handshake, SHALL latch vaddr and owner bit(s), go to ISSUE, and set rr_ptr to the non-winner.
REQ-018 Coalescing: if both requesters are valid in IDLE and vaddr[VA_W-1:12] match, both readies SHALL assert in the same cycle. One walk is performed; both owner bits are set; rr_ptr still toggles.
REQ-019 In ISSUE, ptw_req_valid_o SHALL be 1 with ptw_vaddr_o = latched vaddr. It SHALL hold until ptw_req_ready_i, then go to WAIT. Latency: requester handshake at cycle N -> ptw_req_valid_o at N+1.
REQ-020 ptw_resp_ready_o SHALL be 1 only in WAIT. The resp handshake SHALL register ptw_pte_i and go to RESP.
REQ-021 In RESP, resp_valid_o SHALL be 1 to each owner whose bit is set, with pte_o = registered PTE. Each bit clears independently on that requester's resp handshake. Go to IDLE when all bits are clear. Latency: PTW resp at cycle M -> resp_valid_o at M+1.
REQ-022 pte_o SHALL be stable while resp_valid_o=1. It is don't-care otherwise but driven from the register (no X).
REQ-023 Non-owner resp_valid_o SHALL remain 0. All req_ready_o SHALL be 0 outside IDLE.
REQ-024 A new request SHALL NOT be accepted in the cycle RESP exits; acceptance begins the following cycle in IDLE.
REQ-025 The PTE SHALL be passed unmodified, including invalid (all-zero) PTEs.

Reset
REQ-026 Asserting rst SHALL immediately force: state=IDLE, rr_ptr=0, owner bits=0, latched vaddr=0, PTE register=0.
REQ-027 Output values during and after reset SHALL be: all *_valid_o=0, ptw_resp_ready_o=0, busy_o=0, pte outputs=0, ptw_vaddr_o=0.
REQ-028 Reset mid-walk SHALL abandon the walk without any response. The PTW is reset by the same rst.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, ISSUE, WAIT, RESP), the requester index constants (REQ_ITLB=0, REQ_DTLB=1) and PAGE_SHIFT=12.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2 requests, pointer, grant vector). All other logic is flat.

Verification
REQ-031 Single ITLB request, vaddr 0x00001000; PTW returns 0x1100000F -> ptw_vaddr_o=0x00001000 one cycle after the handshake; itlb_pte_o=0x1100000F one cycle after the PTW resp; dtlb_resp_valid_o stays 0.
REQ-032 Simultaneous ITLB 0x00000000 and DTLB 0x00400000 after reset -> ITLB served first; DTLB accepted only after ITLB resp completes; its PTE returns 0x00000000 unchanged.
REQ-033 Back-to-back ties over three rounds -> grants alternate ITLB, DTLB, ITLB.
REQ-034 Both requesters valid, vaddr 0x00002000 and 0x00002ABC -> exactly one ptw_req handshake; both receive 0x12000003. DTLB holds resp_ready low 3 cycles -> ITLB completes first; busy_o stays high until DTLB accepts.
REQ-035 PTW holds ptw_req_ready_i=0 for 5 cycles, then resp_ready low on the requester side for 4 cycles -> ptw_vaddr_o and pte_o remain stable throughout; no new request is accepted.
REQ-036 rst asserted asynchronously (between clock edges) while in WAIT -> all valids drop immediately; after release, a fresh request completes normally with rr_ptr=0.
